// File: rtl/fp_pack_result.sv
// Final packing stage of the floating-point adder: special code plus normal-path fields in,
// one registered IEEE word and flag set out, with a skid register for full-throughput valid/ready.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    upstream handshake (in_ready = !skid_valid, registered)
//   special              2-bit class code from the classifier (`NAN/`INF/`ZERO/`NORMAL)
//   res_sign/exp/mant    normal-path result; res_exp is a biased two's-complement value, E+2 bits
//   out_valid/out_ready  downstream handshake
//   out_fp               packed W-bit result
//   out_flags            {invalid, overflow, underflow, zero}

`ifndef FP32
`define FP32 0
`endif
`ifndef FP64
`define FP64 1
`endif
`ifndef GET_FP_LEN
`define GET_FP_LEN(f) ((f) == `FP64 ? 64 : 32)
`endif
`ifndef GET_EXP_LEN
`define GET_EXP_LEN(f) ((f) == `FP64 ? 11 : 8)
`endif
`ifndef GET_MANTISSA_HIGH
`define GET_MANTISSA_HIGH(f) ((f) == `FP64 ? 51 : 22)
`endif
`ifndef GET_MANTISSA_LOW
`define GET_MANTISSA_LOW(f) 0
`endif
`ifndef NORMAL
`define NORMAL 2'b00
`endif
`ifndef ZERO
`define ZERO 2'b01
`endif
`ifndef INF
`define INF 2'b10
`endif
`ifndef NAN
`define NAN 2'b11
`endif

module fp_pack_result #(
   parameter int data_format = `FP32,
   localparam int W = `GET_FP_LEN(data_format),
   localparam int E = `GET_EXP_LEN(data_format),
   localparam int M = `GET_MANTISSA_HIGH(data_format)
                      - `GET_MANTISSA_LOW(data_format) + 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [1:0]   special,
   input  logic         res_sign,
   input  logic [E+1:0] res_exp,
   input  logic [M-1:0] res_mant,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_fp,
   output logic [3:0]   out_flags
);

   localparam logic signed [E+1:0] EXP_MAX  = (E+2)'((1 << E) - 1);
   localparam logic signed [E+1:0] EXP_ZERO = '0;

   logic [W-1:0] pk_fp;
   logic [3:0]   pk_flags;
   logic         skid_valid;
   logic [W-1:0] skid_fp;
   logic [3:0]   skid_flags;
   logic         accept;
   logic         ovf;
   logic         unf;

   assign in_ready = !skid_valid;
   assign accept   = in_valid && in_ready;
   assign ovf      = $signed(res_exp) >= EXP_MAX;
   assign unf      = $signed(res_exp) <= EXP_ZERO;

   always_comb begin
      pk_fp    = '0;
      pk_flags = '0;
      unique case (special)
         `NAN: begin
            // canonical quiet NaN, sign forced positive
            pk_fp    = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
            pk_flags = 4'b1000;
         end
         `INF: begin
            pk_fp    = {res_sign, {E{1'b1}}, {M{1'b0}}};
         end
         `ZERO: begin
            pk_fp    = {res_sign, {(W-1){1'b0}}};
            pk_flags = 4'b0001;
         end
         default: begin
            if (ovf) begin
               pk_fp    = {res_sign, {E{1'b1}}, {M{1'b0}}};
               pk_flags = 4'b0100;
            end else if (unf) begin
               pk_fp    = {res_sign, {(W-1){1'b0}}};
               pk_flags = 4'b0011;
            end else begin
               pk_fp    = {res_sign, res_exp[E-1:0], res_mant};
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_fp     <= '0;
         out_flags  <= '0;
         skid_valid <= 1'b0;
         skid_fp    <= '0;
         skid_flags <= '0;
      end else if (skid_valid) begin
         // skid only fills while the output is stalled, so out_valid is 1 here
         if (out_ready) begin
            out_fp     <= skid_fp;
            out_flags  <= skid_flags;
            skid_valid <= 1'b0;
         end
      end else if (accept) begin
         if (!out_valid || out_ready) begin
            out_fp    <= pk_fp;
            out_flags <= pk_flags;
            out_valid <= 1'b1;
         end else begin
            skid_fp    <= pk_fp;
            skid_flags <= pk_flags;
            skid_valid <= 1'b1;
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fp_pack_result.sv
// Self-checking bench for fp_pack_result (FP32): directed literal vectors plus
// a queue-based reference model checked against the DUT on every cycle.

`ifndef NORMAL
`define NORMAL 2'b00
`endif
`ifndef ZERO
`define ZERO 2'b01
`endif
`ifndef INF
`define INF 2'b10
`endif
`ifndef NAN
`define NAN 2'b11
`endif
`ifndef FP32
`define FP32 0
`endif

module tb_fp_pack_result;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  special;
   logic        res_sign;
   logic [9:0]  res_exp;
   logic [22:0] res_mant;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_fp;
   logic [3:0]  out_flags;

   int n_checks = 0;
   int n_fail   = 0;
   bit mon_en   = 1'b0;

   logic [35:0] exp_q[$];

   always #5 clk = ~clk;

   fp_pack_result #(.data_format(`FP32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .special   (special),
      .res_sign  (res_sign),
      .res_exp   (res_exp),
      .res_mant  (res_mant),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_fp    (out_fp),
      .out_flags (out_flags)
   );

   task automatic chk(input string name, input logic [63:0] got,
                      input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
      end
   endtask

   // Reference: the packing rules stated with integer arithmetic on the exponent.
   function automatic logic [35:0] model(input logic [1:0] sp, input logic sg,
                                         input logic [9:0] ex, input logic [22:0] mt);
      int e;
      e = int'($signed(ex));
      case (sp)
         `NAN:  return {32'h7FC0_0000, 4'b1000};
         `INF:  return {sg, 8'hFF, 23'd0, 4'b0000};
         `ZERO: return {sg, 31'd0, 4'b0001};
         default: begin
            if (e >= 255)    return {sg, 8'hFF, 23'd0, 4'b0100};
            else if (e <= 0) return {sg, 31'd0, 4'b0011};
            else             return {sg, 8'(e), mt, 4'b0000};
         end
      endcase
   endfunction

   // Track what the block must hold after each edge.
   always @(posedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         if (out_valid && out_ready && exp_q.size() > 0)
            void'(exp_q.pop_front());
         if (in_valid && in_ready)
            exp_q.push_back(model(special, res_sign, res_exp, res_mant));
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         chk("mon_out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
         chk("mon_in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
         if (out_valid && exp_q.size() > 0)
            chk("mon_data", 64'({out_fp, out_flags}), 64'(exp_q[0]));
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic drive(input logic [1:0] sp, input logic sg,
                        input logic [9:0] ex, input logic [22:0] mt);
      in_valid = 1'b1;
      special  = sp;
      res_sign = sg;
      res_exp  = ex;
      res_mant = mt;
   endtask

   // Single transfer with out_ready high; checks the result one cycle later.
   task automatic one(input string name, input logic [1:0] sp, input logic sg,
                      input logic [9:0] ex, input logic [22:0] mt,
                      input logic [31:0] want_fp, input logic [3:0] want_fl);
      @(posedge clk);
      #1 drive(sp, sg, ex, mt);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk({name, "_valid"}, 64'(out_valid), 64'd1);
      chk({name, "_fp"}, 64'(out_fp), 64'(want_fp));
      chk({name, "_flags"}, 64'(out_flags), 64'(want_fl));
   endtask

   initial begin
      bit acc;
      int budget;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      special   = `NORMAL;
      res_sign  = 1'b0;
      res_exp   = '0;
      res_mant  = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_out_fp", 64'(out_fp), 64'd0);
      chk("reset_out_flags", 64'(out_flags), 64'd0);
      chk("reset_in_ready", 64'(in_ready), 64'd1);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // literal pins of the packing rules
      one("nan", `NAN, 1'b1, 10'd5, 23'h1234, 32'h7FC0_0000, 4'b1000);
      one("inf_neg", `INF, 1'b1, 10'd0, 23'h0, 32'hFF80_0000, 4'b0000);
      one("zero_neg", `ZERO, 1'b1, 10'd0, 23'h0, 32'h8000_0000, 4'b0001);
      one("one", `NORMAL, 1'b0, 10'd127, 23'h0, 32'h3F80_0000, 4'b0000);
      one("ovf255", `NORMAL, 1'b0, 10'd255, 23'h0, 32'h7F80_0000, 4'b0100);
      one("unf_neg3", `NORMAL, 1'b1, -10'sd3, 23'h7, 32'h8000_0000, 4'b0011);
      one("unf_0", `NORMAL, 1'b0, 10'd0, 23'h5, 32'h0000_0000, 4'b0011);
      one("max_norm", `NORMAL, 1'b0, 10'd254, 23'h7FFFFF, 32'h7F7F_FFFF, 4'b0000);
      one("min_norm", `NORMAL, 1'b1, 10'd1, 23'h0, 32'h8080_0000, 4'b0000);
      one("ovf300", `NORMAL, 1'b1, 10'd300, 23'h1, 32'hFF80_0000, 4'b0100);

      // backpressure: A held, B skidded, C waits upstream
      @(posedge clk);
      #1 out_ready = 1'b0;
      drive(`NORMAL, 1'b0, 10'd127, 23'h0);
      @(posedge clk);
      #1 drive(`NORMAL, 1'b1, 10'd128, 23'h200000);
      @(posedge clk);
      #1 drive(`INF, 1'b0, 10'd0, 23'h0);
      @(negedge clk);
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      chk("bp_hold_a", 64'(out_fp), 64'h3F80_0000);
      @(posedge clk);
      @(negedge clk);
      chk("bp_hold_a2", 64'(out_fp), 64'h3F80_0000);
      chk("bp_in_ready_low2", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_b", 64'(out_fp), 64'hC020_0000);
      chk("bp_in_ready_back", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk("bp_c", 64'(out_fp), 64'h7F80_0000);
      @(posedge clk);
      @(negedge clk);
      chk("bp_drained", 64'(out_valid), 64'd0);

      // streaming at full rate
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1 drive(2'($urandom), 1'($urandom),
                  10'($urandom_range(0, 320)) - 10'd20, 23'($urandom));
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (2) @(posedge clk);

      // random valid / ready to exercise the skid path
      acc = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         acc = in_valid && in_ready;
         #1;
         if (acc || !in_valid) begin
            in_valid = ($urandom % 4) != 0;
            special  = 2'($urandom);
            res_sign = 1'($urandom);
            res_exp  = 10'($urandom);
            res_mant = 23'($urandom);
         end
         out_ready = ($urandom % 3) != 0;
      end
      #1 in_valid = 1'b0;
      out_ready = 1'b1;
      budget = 0;
      while (out_valid && budget < 10) begin
         @(posedge clk);
         #1 budget++;
      end
      chk("drain_done", 64'(out_valid), 64'd0);

      // reset with both registers full
      @(posedge clk);
      #1 out_ready = 1'b0;
      drive(`NORMAL, 1'b0, 10'd100, 23'h1);
      @(posedge clk);
      #1 drive(`NORMAL, 1'b0, 10'd101, 23'h2);
      @(posedge clk);
      #1;
      chk("rst_full_skid", 64'(in_ready), 64'd0);
      rst_n = 1'b0;
      drive(`NORMAL, 1'b0, 10'd102, 23'h3);
      @(posedge clk);
      #1 rst_n = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
      chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_no_stale", 64'(out_valid), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
